// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search controller:
// state encoding and the flag sanity helper.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRY  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic onehot3(input logic gt, input logic eq, input logic lt);
        return ( gt & ~eq & ~lt) |
               (~gt &  eq & ~lt) |
               (~gt & ~eq &  lt);
    endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives a candidate onto an external
// magnitude comparator and resolves the target one bit per clock.
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int SW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [SW-1:0]    steps,
    output logic             err
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SW-1:0]    idx_q, idx_d;
    logic [SW-1:0]    steps_q, steps_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] acc_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            guess_q  <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            steps_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            steps_q  <= steps_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        guess_d  = guess_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        steps_d  = steps_q;
        result_d = result_q;
        err_d    = err_q;
        // A gt verdict means the trial bit belongs in the answer; lt leaves it cleared.
        acc_n    = cmp_gt ? guess_q : acc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = TRY;
                    guess_d = MSB;
                    acc_d   = '0;
                    idx_d   = SW'(WIDTH - 1);
                    steps_d = '0;
                    err_d   = 1'b0;
                end
            end
            TRY: begin
                steps_d = steps_q + SW'(1);
                if (!onehot3(cmp_gt, cmp_eq, cmp_lt)) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = DONE;
                end else if (cmp_eq) begin
                    result_d = guess_q;
                    state_d  = DONE;
                end else if (idx_q == '0) begin
                    result_d = acc_n;
                    state_d  = DONE;
                end else begin
                    acc_d   = acc_n;
                    guess_d = acc_n | (ONE << (idx_q - SW'(1)));
                    idx_d   = idx_q - SW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign guess  = guess_q;
    assign busy   = (state_q == TRY);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign steps  = steps_q;
    assign err    = err_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl: a behavioural comparator plus an
// interval-halving reference model predict every trial, the result and the step count.
module tb_sar_search_ctrl;

    localparam int WIDTH = 4;
    localparam int SW    = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             cmp_gt, cmp_eq, cmp_lt;
    logic [WIDTH-1:0] guess;
    logic             busy, done;
    logic [WIDTH-1:0] result;
    logic [SW-1:0]    steps;
    logic             err;

    logic [WIDTH-1:0] target;
    logic             ovr;

    int checks;
    int errors;
    int lastResult;
    int expGuess[WIDTH];
    int expTrials;
    int expResult;
    int expErr;

    sar_search_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmp_gt (cmp_gt),
        .cmp_eq (cmp_eq),
        .cmp_lt (cmp_lt),
        .guess  (guess),
        .busy   (busy),
        .done   (done),
        .result (result),
        .steps  (steps),
        .err    (err)
    );

    // Behavioural comparator (a=target, b=guess); ovr forces an illegal gt+lt pattern.
    assign cmp_gt = ovr ? 1'b1 : (target > guess);
    assign cmp_eq = ovr ? 1'b0 : (target == guess);
    assign cmp_lt = ovr ? 1'b1 : (target < guess);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: binary search over the interval [lo,hi] with upper-midpoint probes.
    task automatic modelSearch(input int tgt, input int badTrial);
        int lo, hi, g;
        lo = 0;
        hi = (1 << WIDTH) - 1;
        expTrials = WIDTH;
        expResult = -1;
        expErr    = 0;
        for (int k = 0; k < WIDTH; k++) begin
            g = (lo + hi + 1) / 2;
            expGuess[k] = g;
            if (k == badTrial) begin
                expTrials = k + 1;
                expResult = 0;
                expErr    = 1;
                break;
            end
            if (g == tgt) begin
                expTrials = k + 1;
                expResult = g;
                break;
            end
            if (tgt > g) lo = g;
            else         hi = g - 1;
        end
        if (expResult < 0) expResult = lo;
    endtask

    // Called at a negedge while the DUT is idle; returns at a negedge with the DUT idle again.
    task automatic applyStimulus(input int tgt, input int badTrial, input int repulseAt);
        modelSearch(tgt, badTrial);
        target = WIDTH'(tgt);
        checkOutput("result_held_before_start", int'(result), lastResult);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("steps_cleared", int'(steps), 0);
        checkOutput("err_cleared", int'(err), 0);
        for (int k = 0; k < expTrials; k++) begin
            checkOutput($sformatf("guess_t%0d", k), int'(guess), expGuess[k]);
            checkOutput($sformatf("busy_t%0d", k), int'(busy), 1);
            checkOutput($sformatf("done_low_t%0d", k), int'(done), 0);
            ovr   = (k == badTrial);
            start = (k == repulseAt);
            @(negedge clk);
            ovr   = 1'b0;
            start = 1'b0;
        end
        checkOutput("done_pulse", int'(done), 1);
        checkOutput("busy_low_done", int'(busy), 0);
        checkOutput("result", int'(result), expResult);
        checkOutput("steps", int'(steps), expTrials);
        checkOutput("err", int'(err), expErr);
        checkOutput("guess_hold", int'(guess), expGuess[expTrials-1]);
        @(negedge clk);
        checkOutput("done_one_cycle", int'(done), 0);
        checkOutput("busy_idle", int'(busy), 0);
        checkOutput("result_held", int'(result), expResult);
        lastResult = expResult;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        lastResult = 0;
        start      = 1'b0;
        ovr        = 1'b0;
        target     = '0;
        rst_n      = 1'b0;
        #3;
        checkOutput("rst_guess", int'(guess), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_result", int'(result), 0);
        checkOutput("rst_steps", int'(steps), 0);
        checkOutput("rst_err", int'(err), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(5, -1, -1);
        applyStimulus(8, -1, -1);
        applyStimulus(0, -1, -1);
        applyStimulus(15, -1, -1);
        applyStimulus(9, 1, -1);
        applyStimulus(6, -1, 1);
        applyStimulus(3, -1, 0);

        for (int n = 0; n < 24; n++) begin
            applyStimulus(int'($urandom_range(0, (1 << WIDTH) - 1)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WIDTH - 1)) : -1,
                          ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, WIDTH - 1)) : -1);
        end

        // Abort a search partway through with an asynchronous reset.
        target = 4'd11;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_guess", int'(guess), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_result", int'(result), 0);
        checkOutput("abort_steps", int'(steps), 0);
        checkOutput("abort_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < WIDTH + 2; k++) begin
            @(negedge clk);
            checkOutput("abort_no_done", int'(done), 0);
            checkOutput("abort_stays_idle", int'(busy), 0);
        end
        lastResult = 0;
        applyStimulus(12, -1, -1);
        applyStimulus(7, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
